// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the shared 32-bit memory port: grants one of four requesters,
// steers the address/wdata/read-write muxes and runs the mem_req/mem_ack handshake.
// Define ARB_TIMEOUT_EN to abort accesses that see no mem_ack within TIMEOUT_CYCLES.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [3:0] req_we,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       we_sel,
  output logic       mem_req,
  input  logic       mem_ack,
  output logic [3:0] done,
  output logic       err
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT_CYCLES out of range 2..255");
  end

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic       we_sel_q, we_sel_d;
  logic       mem_req_q, mem_req_d;
  logic [3:0] done_q, done_d;
  logic [1:0] last_q, last_d;
  logic       found;
  logic [1:0] win;
  logic       abort_c;

  // Search starts one past the last served requester; offset 4 wraps back to last itself.
  always_comb begin
    found = 1'b0;
    win   = last_q;
    for (int unsigned i = 1; i <= 4; i++) begin
      if (!found && req[last_q + 2'(i)]) begin
        found = 1'b1;
        win   = last_q + 2'(i);
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       err_q;

  // A same-cycle mem_ack takes priority over the timeout.
  assign abort_c = (state_q == BUSY) && !mem_ack && (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (state_q == BUSY && !mem_ack) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= abort_c;
    end
  end

  assign err = err_q;
`else
  assign abort_c = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    we_sel_d  = we_sel_q;
    mem_req_d = mem_req_q;
    last_d    = last_q;
    done_d    = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d     = 4'b0001 << win;
          sel_d     = win;
          we_sel_d  = req_we[win];
          mem_req_d = 1'b1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (mem_ack || abort_c) begin
          gnt_d     = '0;
          mem_req_d = 1'b0;
          done_d    = 4'b0001 << sel_q;
          last_d    = sel_q;
          state_d   = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      sel_q     <= '0;
      we_sel_q  <= 1'b0;
      mem_req_q <= 1'b0;
      done_q    <= '0;
      last_q    <= 2'd3;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      we_sel_q  <= we_sel_d;
      mem_req_q <= mem_req_d;
      done_q    <= done_d;
      last_q    <= last_d;
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign we_sel  = we_sel_q;
  assign mem_req = mem_req_q;
  assign done    = done_q;

endmodule
